// File: rtl/mpc_bank_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : mpc_bank_req_arb
// Brief    : Round-robin arbiter for one cache bank. Stores are given a
//            write-buffer slot from a free bitmap.
// Revision : 1.0
// ============================================================================

package mpc_bank_req_arb_pkg;
    localparam logic [1:0] MPC_OP_LOAD  = 2'd0;
    localparam logic [1:0] MPC_OP_STORE = 2'd1;
    localparam logic [1:0] MPC_OP_AMO   = 2'd2;
    localparam logic [1:0] MPC_OP_FENCE = 2'd3;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } channel_req_t;

    typedef struct packed {
        logic [2:0]  channel_1hot_id;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  wbuffer_id;
    } bank_req_t;
endpackage

module mpc_bank_req_arb
    import mpc_bank_req_arb_pkg::*;
#(
    parameter int NUM_CHANNELS = 3,
    parameter int WBUF_SIZE    = 32,
    parameter int WBUF_W       = $clog2(WBUF_SIZE)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic         [NUM_CHANNELS-1:0]        ch_valid_i,
    input  channel_req_t [NUM_CHANNELS-1:0]        ch_req_i,
    output logic         [NUM_CHANNELS-1:0]        ch_ready_o,
    output logic                                   bank_valid_o,
    output bank_req_t                              bank_req_o,
    input  logic                                   bank_ready_i,
    input  logic                                   wbuf_free_valid_i,
    input  logic         [WBUF_W-1:0]              wbuf_free_id_i,
    output logic         [WBUF_W:0]                wbuf_count_o,
    output logic                                   wbuf_full_o
);

    localparam logic [WBUF_W:0] c_count_full = WBUF_SIZE[WBUF_W:0];

    logic [1:0]            r_rr_last;
    logic [WBUF_SIZE-1:0]  r_free;
    logic [WBUF_W:0]       r_count;
    logic                  r_full;
    logic                  r_bank_valid;
    bank_req_t             r_bank_req;

    logic [NUM_CHANNELS-1:0] w_elig;
    logic                  w_any_free;
    logic                  w_can_load;
    logic                  w_grant_valid;
    logic [1:0]            w_grant;
    logic [1:0]            w_cand1;
    logic [1:0]            w_cand2;
    channel_req_t          w_grant_req;
    logic                  w_is_store;
    logic                  w_do_grant;
    logic                  w_alloc;
    logic                  w_release;
    logic [WBUF_W-1:0]     w_alloc_id;
    logic [WBUF_SIZE-1:0]  w_free_nxt;
    logic [WBUF_W:0]       w_count_nxt;

    function automatic logic [1:0] f_rr_step(input logic [1:0] base, input logic [1:0] step);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, step};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    assign w_any_free = |r_free;
    assign w_can_load = !r_bank_valid || bank_ready_i;

    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_elig[i] = ch_valid_i[i] && ((ch_req_i[i].op != MPC_OP_STORE) || w_any_free);
        end
    end

    // Search order is rr_last+1, rr_last+2, rr_last (wrapping modulo 3).
    assign w_cand1 = f_rr_step(r_rr_last, 2'd1);
    assign w_cand2 = f_rr_step(r_rr_last, 2'd2);

    always_comb begin
        w_grant_valid = 1'b1;
        w_grant       = w_cand1;
        if (w_elig[w_cand1]) begin
            w_grant = w_cand1;
        end else if (w_elig[w_cand2]) begin
            w_grant = w_cand2;
        end else if (w_elig[r_rr_last]) begin
            w_grant = r_rr_last;
        end else begin
            w_grant_valid = 1'b0;
        end
    end

    assign w_grant_req = ch_req_i[w_grant];
    assign w_is_store  = (w_grant_req.op == MPC_OP_STORE);
    assign w_do_grant  = w_can_load && w_grant_valid && !rst_i;
    assign w_alloc     = w_do_grant && w_is_store;
    // Only a genuinely allocated slot counts as a release; double frees are ignored.
    assign w_release   = wbuf_free_valid_i && !r_free[wbuf_free_id_i];

    always_comb begin
        w_alloc_id = '0;
        for (int i = WBUF_SIZE - 1; i >= 0; i--) begin
            if (r_free[i]) w_alloc_id = WBUF_W'(i);
        end
    end

    always_comb begin
        w_free_nxt = r_free;
        if (wbuf_free_valid_i) w_free_nxt[wbuf_free_id_i] = 1'b1;
        if (w_alloc)           w_free_nxt[w_alloc_id]     = 1'b0;
    end

    assign w_count_nxt = r_count + {{WBUF_W{1'b0}}, w_alloc} - {{WBUF_W{1'b0}}, w_release};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_last    <= 2'd2;
            r_free       <= '1;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_bank_valid <= 1'b0;
            r_bank_req   <= '0;
        end else begin
            r_free  <= w_free_nxt;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_count_full);
            if (w_do_grant) r_rr_last <= w_grant;
            if (w_can_load) begin
                r_bank_valid <= w_grant_valid;
                if (w_grant_valid) begin
                    r_bank_req.channel_1hot_id <= 3'b001 << w_grant;
                    r_bank_req.op              <= w_grant_req.op;
                    r_bank_req.addr            <= w_grant_req.addr;
                    r_bank_req.wdata           <= w_grant_req.wdata;
                    r_bank_req.wbuffer_id      <= w_is_store ? w_alloc_id : '0;
                end
            end
        end
    end

    assign ch_ready_o   = w_do_grant ? (3'b001 << w_grant) : 3'b000;
    assign bank_valid_o = r_bank_valid;
    assign bank_req_o   = r_bank_req;
    assign wbuf_count_o = r_count;
    assign wbuf_full_o  = r_full;

endmodule
`default_nettype wire

// File: tb/tb_mpc_bank_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpc_bank_req_arb
// Brief    : Directed self-checking bench for mpc_bank_req_arb.
// Revision : 1.0
// ============================================================================
module tb_mpc_bank_req_arb;
    import mpc_bank_req_arb_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [2:0]         ch_valid = '0;
    channel_req_t [2:0] ch_req = '0;
    logic [2:0]         ch_ready;
    logic               bank_valid;
    bank_req_t          bank_req;
    logic               bank_ready = 1'b1;
    logic               free_valid = 1'b0;
    logic [4:0]         free_id = '0;
    logic [5:0]         count;
    logic               full;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mpc_bank_req_arb dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .ch_valid_i        (ch_valid),
        .ch_req_i          (ch_req),
        .ch_ready_o        (ch_ready),
        .bank_valid_o      (bank_valid),
        .bank_req_o        (bank_req),
        .bank_ready_i      (bank_ready),
        .wbuf_free_valid_i (free_valid),
        .wbuf_free_id_i    (free_id),
        .wbuf_count_o      (count),
        .wbuf_full_o       (full)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input logic [1:0] idx, input logic [1:0] op, input logic [31:0] addr);
        ch_req[idx].op    = op;
        ch_req[idx].addr  = addr;
        ch_req[idx].wdata = addr ^ 32'hA5A5_0000;
    endtask

    task automatic test_reset();
        rst = 1'b1; bank_ready = 1'b1; ch_valid = 3'b111;
        set_ch(2'd0, MPC_OP_LOAD, 32'h100);
        set_ch(2'd1, MPC_OP_LOAD, 32'h200);
        set_ch(2'd2, MPC_OP_LOAD, 32'h300);
        cyc(); cyc(); #1;
        checks++;
        if (ch_ready !== 3'b000) begin
            failures++; $display("FAIL reset_ready: got %b want 000", ch_ready);
        end
        checks++;
        if ({bank_valid, count, full} !== {1'b0, 6'd0, 1'b0}) begin
            failures++; $display("FAIL reset_state: valid=%b count=%0d full=%b want 0/0/0", bank_valid, count, full);
        end
        checks++;
        if (bank_req !== '0) begin
            failures++; $display("FAIL reset_req: got %h want 0", bank_req);
        end
        rst = 1'b0; ch_valid = 3'b000;
    endtask

    task automatic test_load_contention();
        int seq [4] = '{0, 1, 2, 0};
        logic [2:0]  exp_oh;
        logic [31:0] exp_addr;
        ch_valid = 3'b111;
        for (int n = 0; n < 4; n++) begin
            exp_oh   = 3'b001 << seq[n];
            exp_addr = 32'h100 * (seq[n] + 1);
            #1;
            checks++;
            if (ch_ready !== exp_oh) begin
                failures++; $display("FAIL rr_ready[%0d]: got %b want %b", n, ch_ready, exp_oh);
            end
            cyc();
            checks++;
            if ({bank_valid, bank_req.channel_1hot_id, bank_req.addr, bank_req.wbuffer_id} !==
                {1'b1, exp_oh, exp_addr, 5'd0}) begin
                failures++; $display("FAIL rr_out[%0d]: v=%b oh=%b addr=%h id=%0d want 1/%b/%h/0",
                                     n, bank_valid, bank_req.channel_1hot_id, bank_req.addr,
                                     bank_req.wbuffer_id, exp_oh, exp_addr);
            end
        end
        ch_valid = 3'b000;
        cyc();
        checks++;
        if (bank_valid !== 1'b0) begin
            failures++; $display("FAIL rr_drain: valid=%b want 0", bank_valid);
        end
    endtask

    task automatic test_backpressure();
        set_ch(2'd1, MPC_OP_STORE, 32'h0000_1040);
        ch_valid = 3'b010; bank_ready = 1'b1;
        cyc();
        checks++;
        if ({bank_valid, bank_req.channel_1hot_id, bank_req.op, bank_req.addr, bank_req.wbuffer_id, count} !==
            {1'b1, 3'b010, MPC_OP_STORE, 32'h0000_1040, 5'd0, 6'd1}) begin
            failures++; $display("FAIL bp_load: oh=%b op=%0d addr=%h id=%0d count=%0d want 010/1/1040/0/1",
                                 bank_req.channel_1hot_id, bank_req.op, bank_req.addr, bank_req.wbuffer_id, count);
        end
        bank_ready = 1'b0;
        set_ch(2'd1, MPC_OP_LOAD, 32'h0000_1044);
        ch_valid = 3'b111;
        for (int n = 0; n < 4; n++) begin
            #1;
            checks++;
            if (ch_ready !== 3'b000) begin
                failures++; $display("FAIL bp_ready[%0d]: got %b want 000", n, ch_ready);
            end
            cyc();
            checks++;
            if ({bank_valid, bank_req.channel_1hot_id, bank_req.op, bank_req.addr} !==
                {1'b1, 3'b010, MPC_OP_STORE, 32'h0000_1040}) begin
                failures++; $display("FAIL bp_hold[%0d]: v=%b oh=%b addr=%h want 1/010/1040",
                                     n, bank_valid, bank_req.channel_1hot_id, bank_req.addr);
            end
        end
        bank_ready = 1'b1;
        #1;
        checks++;
        if (ch_ready !== 3'b100) begin
            failures++; $display("FAIL bp_release_ready: got %b want 100", ch_ready);
        end
        cyc();
        checks++;
        if ({bank_req.channel_1hot_id, bank_req.addr} !== {3'b100, 32'h300}) begin
            failures++; $display("FAIL bp_release_out: oh=%b addr=%h want 100/300",
                                 bank_req.channel_1hot_id, bank_req.addr);
        end
        ch_valid = 3'b000; free_valid = 1'b1; free_id = 5'd0;
        cyc();
        free_valid = 1'b0;
        checks++;
        if (count !== 6'd0) begin
            failures++; $display("FAIL bp_free: count=%0d want 0", count);
        end
    endtask

    task automatic test_exhaustion();
        set_ch(2'd0, MPC_OP_STORE, 32'h2000);
        ch_valid = 3'b001;
        for (int i = 0; i < 32; i++) begin
            cyc();
            checks++;
            if ({bank_req.channel_1hot_id, bank_req.wbuffer_id} !== {3'b001, 5'(i)}) begin
                failures++; $display("FAIL ex_alloc[%0d]: oh=%b id=%0d want 001/%0d",
                                     i, bank_req.channel_1hot_id, bank_req.wbuffer_id, i);
            end
        end
        checks++;
        if ({count, full} !== {6'd32, 1'b1}) begin
            failures++; $display("FAIL ex_full: count=%0d full=%b want 32/1", count, full);
        end
        set_ch(2'd2, MPC_OP_LOAD, 32'h3000);
        ch_valid = 3'b101;
        #1;
        checks++;
        if (ch_ready !== 3'b100) begin
            failures++; $display("FAIL ex_load_bypass: ready=%b want 100", ch_ready);
        end
        cyc();
        checks++;
        if ({bank_req.channel_1hot_id, bank_req.op, bank_req.wbuffer_id} !== {3'b100, MPC_OP_LOAD, 5'd0}) begin
            failures++; $display("FAIL ex_load_out: oh=%b op=%0d id=%0d want 100/0/0",
                                 bank_req.channel_1hot_id, bank_req.op, bank_req.wbuffer_id);
        end
        ch_valid = 3'b001; free_valid = 1'b1; free_id = 5'd7;
        #1;
        checks++;
        if (ch_ready !== 3'b000) begin
            failures++; $display("FAIL ex_stall: ready=%b want 000", ch_ready);
        end
        cyc();
        free_valid = 1'b0;
        checks++;
        if ({count, full} !== {6'd31, 1'b0}) begin
            failures++; $display("FAIL ex_after_free: count=%0d full=%b want 31/0", count, full);
        end
        #1;
        checks++;
        if (ch_ready !== 3'b001) begin
            failures++; $display("FAIL ex_regrant_ready: ready=%b want 001", ch_ready);
        end
        cyc();
        checks++;
        if ({bank_req.channel_1hot_id, bank_req.wbuffer_id, count, full} !== {3'b001, 5'd7, 6'd32, 1'b1}) begin
            failures++; $display("FAIL ex_regrant: oh=%b id=%0d count=%0d full=%b want 001/7/32/1",
                                 bank_req.channel_1hot_id, bank_req.wbuffer_id, count, full);
        end
        ch_valid = 3'b000;
        cyc();
    endtask

    task automatic test_same_cycle();
        rst = 1'b1; ch_valid = 3'b000;
        cyc();
        rst = 1'b0;
        set_ch(2'd0, MPC_OP_STORE, 32'h4000);
        ch_valid = 3'b001;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (bank_req.wbuffer_id !== 5'(i)) begin
                failures++; $display("FAIL sc_prefill[%0d]: id=%0d want %0d", i, bank_req.wbuffer_id, i);
            end
        end
        free_valid = 1'b1; free_id = 5'd2;
        cyc();
        free_valid = 1'b0;
        checks++;
        if ({bank_req.wbuffer_id, count} !== {5'd4, 6'd4}) begin
            failures++; $display("FAIL sc_alloc_free: id=%0d count=%0d want 4/4", bank_req.wbuffer_id, count);
        end
        cyc();
        checks++;
        if ({bank_req.wbuffer_id, count} !== {5'd2, 6'd5}) begin
            failures++; $display("FAIL sc_reuse: id=%0d count=%0d want 2/5", bank_req.wbuffer_id, count);
        end
        ch_valid = 3'b000;
        cyc();
    endtask

    task automatic test_double_free_reset();
        free_valid = 1'b1; free_id = 5'd9;
        cyc();
        free_valid = 1'b0;
        checks++;
        if (count !== 6'd5) begin
            failures++; $display("FAIL df_count: count=%0d want 5", count);
        end
        set_ch(2'd1, MPC_OP_AMO, 32'h5000);
        ch_valid = 3'b010;
        cyc();
        checks++;
        if ({bank_valid, bank_req.channel_1hot_id, bank_req.op, bank_req.wbuffer_id, count} !==
            {1'b1, 3'b010, MPC_OP_AMO, 5'd0, 6'd5}) begin
            failures++; $display("FAIL df_amo: v=%b oh=%b op=%0d id=%0d count=%0d want 1/010/2/0/5",
                                 bank_valid, bank_req.channel_1hot_id, bank_req.op, bank_req.wbuffer_id, count);
        end
        rst = 1'b1;
        set_ch(2'd0, MPC_OP_LOAD, 32'h100);
        set_ch(2'd1, MPC_OP_LOAD, 32'h200);
        ch_valid = 3'b111;
        #1;
        checks++;
        if (ch_ready !== 3'b000) begin
            failures++; $display("FAIL rst_mid_ready: ready=%b want 000", ch_ready);
        end
        cyc();
        rst = 1'b0;
        checks++;
        if ({bank_valid, count, full} !== {1'b0, 6'd0, 1'b0}) begin
            failures++; $display("FAIL rst_mid_state: v=%b count=%0d full=%b want 0/0/0", bank_valid, count, full);
        end
        #1;
        checks++;
        if (ch_ready !== 3'b001) begin
            failures++; $display("FAIL rst_mid_first: ready=%b want 001", ch_ready);
        end
        cyc();
        checks++;
        if ({bank_valid, bank_req.channel_1hot_id} !== {1'b1, 3'b001}) begin
            failures++; $display("FAIL rst_mid_out: v=%b oh=%b want 1/001", bank_valid, bank_req.channel_1hot_id);
        end
        ch_valid = 3'b000;
        cyc();
    endtask

    initial begin
        test_reset();
        test_load_contention();
        test_backpressure();
        test_exhaustion();
        test_same_cycle();
        test_double_free_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mpc_bank_req_arb.md
Name: mpc_bank_req_arb

Overview:
- Per-bank request arbiter that sits directly upstream of a cache bank.
- Accepts channel_req_t requests from 3 channel ports and picks one per cycle by round-robin.
- For stores, allocates a write-buffer slot id from a free bitmap; loads carry no slot.
- Emits a registered bank_req_t with a valid/ready handshake; the bank returns freed slot ids on a release port.

Parameters:
- NUM_CHANNELS, 3, number of channel ports; fixed by the 3-bit channel_1hot_id.
- WBUF_SIZE, 32, number of write-buffer slots; fixed by the 5-bit wbuffer_id.
- WBUF_W, $clog2(WBUF_SIZE)=5, slot id width.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- ch_valid_i  input  3  per-channel request valid
- ch_req_i  input  3 x channel_req_t  per-channel request (op, addr, wdata)
- ch_ready_o  output  3  per-channel accept; at most one bit set
- bank_valid_o  output  1  output request valid
- bank_req_o  output  bank_req_t  output request
- bank_ready_i  input  1  bank accepts output
- wbuf_free_valid_i  input  1  bank releases a slot
- wbuf_free_id_i  input  5  id of the released slot
- wbuf_count_o  output  6  number of allocated slots (0..32)
- wbuf_full_o  output  1  wbuf_count_o == 32

Behaviour:
- Reset, synchronous on rst_i=1:
  - bank_valid_o=0; bank_req_o=0.
  - rr_last=2, so channel 0 has first priority.
  - Free bitmap all ones (all slots free); wbuf_count_o=0; wbuf_full_o=0.
  - ch_ready_o forced to 0 while rst_i=1.
  - Reset mid-operation discards the held output and all allocations; no frees are required afterwards.
- Eligibility: channel i is eligible if ch_valid_i[i] && (op!=MPC_OP_STORE || any slot free).
  - A store that cannot get a slot masks only its own channel. Loads keep flowing.
- Output register:
  - can_load = !bank_valid_o || bank_ready_i (full-throughput pipe register).
  - On can_load with no eligible channel, bank_valid_o goes to 0 next cycle.
- Grant:
  - When can_load and at least one channel is eligible, grant the first eligible channel searching rr_last+1, rr_last+2, ... modulo 3.
  - ch_ready_o[grant]=1 in the same cycle (combinational).
  - On the next edge, rr_last=grant.
  - rr_last does not change when there is no grant.
- Output fields on grant, registered with 1-cycle latency:
  - channel_1hot_id = 1<<grant
  - op, addr, wdata copied from the request
  - wbuffer_id = lowest-index free slot for stores; 0 for loads and all other op codes (non-store ops never allocate).
- Hold: while bank_valid_o && !bank_ready_i, bank_req_o is held stable and ch_ready_o=0.
- Allocation: on a store grant, bitmap[id] is cleared at the edge.
- Free: on wbuf_free_valid_i, bitmap[wbuf_free_id_i] is set at the edge.
  - Freeing an already-free id is a no-op; wbuf_count_o is unchanged.
- Simultaneous allocate and free in one cycle:
  - The allocator reads the pre-edge bitmap, so the freed id is not reusable until the next cycle.
  - wbuf_count_o = count + alloc - valid_free, so it is unchanged when both happen.
  - When full, a free in cycle N makes the store grantable in cycle N+1.
- wbuf_count_o and wbuf_full_o are registered and consistent with the bitmap at all times.

Test Plan:
- Three-way load contention:
  - After reset, all 3 channels hold a load; bank_ready_i=1.
  - Required: grants to ch0, ch1, ch2 in consecutive cycles, then ch0 again.
  - Required: bank_req_o.channel_1hot_id = 001, 010, 100, 001, each one cycle after its grant; wbuffer_id=0.
- Backpressure:
  - Hold bank_ready_i=0 for 4 cycles with a store from ch1 (addr 0x0000_1040) in the output register.
  - Required: bank_req_o stable, ch_ready_o=000 throughout.
  - On release, the next grant follows the round-robin order from ch1.
- Slot exhaustion:
  - Issue 32 stores on ch0. Required: wbuffer_id 0..31 in order; wbuf_count_o=32; wbuf_full_o=1.
  - A 33rd store on ch0 plus a load on ch2. Required: the load is granted; ch0 stalls.
  - Free id 7. Required: the next cycle grants ch0 with wbuffer_id=7; wbuf_count_o returns to 32.
- Same-cycle alloc and free:
  - With slots 0-3 allocated, in one cycle grant a store and free id 2.
  - Required: the store gets id 4; wbuf_count_o stays 4; the following store gets id 2.
- Double free and reset mid-operation:
  - Free id 9 while it is already free. Required: no change to wbuf_count_o.
  - Assert rst_i for 1 cycle while bank_valid_o=1 and count=5.
  - Required next cycle: bank_valid_o=0, wbuf_count_o=0, and the first grant goes to ch0.
